nibble_splitter: RTL and testbench

//  Inverse of the team's {a,b} concatenation: takes one WORD_W-bit word via valid/ready and

---
 rtl/nibble_splitter_pkg.sv | 37 +++
 rtl/nibble_splitter_if.sv | 39 +++
 rtl/nibble_splitter_part_counter.sv | 32 +++
 rtl/nibble_splitter.sv | 119 +++++++++++
 tb/tb_nibble_splitter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_splitter_pkg.sv
// -----------------------------------------------------------------------------
// splitter_pkg
// Shared definitions for the nibble_splitter slice:
//   state_t     - two-state FSM encoding (ST_IDLE=0, ST_SEND=1)
//   clog2_min1  - ceiling log2 with a floor of 1 (index width helper)
//   num_parts   - number of PART_W slices in a WORD_W word
// Ports: none (package).
// Configuration macro used elsewhere in the slice: SPLIT_LSB_FIRST_EN.
// -----------------------------------------------------------------------------
package splitter_pkg;

    localparam int unsigned DEF_WORD_W = 8;
    localparam int unsigned DEF_PART_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // An index of a single slot still needs one bit of storage.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned num_parts(input int unsigned word_w,
                                              input int unsigned part_w);
        return word_w / part_w;
    endfunction

endpackage

// File: rtl/nibble_splitter_if.sv
// -----------------------------------------------------------------------------
// nibble_splitter_if
// Bundles both handshakes of the splitter.
//   in_valid/in_ready/in_data            word side (producer -> splitter)
//   out_valid/out_ready/out_data/
//   out_idx/out_last                     slice side (splitter -> consumer)
// Modports:
//   slave  - the splitter itself
//   master - the environment (producer + consumer)
// Parameters: WORD_W (word width), PART_W (slice width).
// -----------------------------------------------------------------------------
interface nibble_splitter_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned PART_W = 4
);
    import splitter_pkg::*;

    localparam int unsigned IDX_W = clog2_min1(num_parts(WORD_W, PART_W));

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PART_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/nibble_splitter_part_counter.sv
// -----------------------------------------------------------------------------
// part_counter
// Modulo-NUM_PARTS slice index counter.
//   clk, rst  clock, synchronous active-high reset
//   clr       force count to 0 (new word latched)
//   inc       advance by one, wrapping after NUM_PARTS-1
//   count     current index
//   last      count == NUM_PARTS-1
// -----------------------------------------------------------------------------
module part_counter #(
    parameter int unsigned NUM_PARTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             last
);

    assign last = (count == IDX_W'(NUM_PARTS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_splitter.sv
// -----------------------------------------------------------------------------
// nibble_splitter
// Accepts one WORD_W word over a valid/ready handshake and emits it as
// NUM_PARTS = WORD_W/PART_W slices, one per accepted output beat. One word is
// buffered; the next word may be latched on the final slice's handshake so
// back-to-back words stream without a bubble.
// Ports:
//   clk   clock (posedge)
//   rst   synchronous active-high reset
//   bus   nibble_splitter_if.slave: in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data/out_idx/out_last
// Configuration:
//   SPLIT_LSB_FIRST_EN defined   -> slice k = word[k*PART_W +: PART_W]
//   SPLIT_LSB_FIRST_EN undefined -> slice k = word[WORD_W-1-k*PART_W -: PART_W]
// -----------------------------------------------------------------------------
module nibble_splitter
    import splitter_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned PART_W = DEF_PART_W
) (
    input  logic              clk,
    input  logic              rst,
    nibble_splitter_if.slave  bus
);

    localparam int unsigned NUM_PARTS = num_parts(WORD_W, PART_W);
    localparam int unsigned IDX_W     = clog2_min1(NUM_PARTS);

    generate
        if ((WORD_W % PART_W) != 0 || WORD_W < 2 * PART_W) begin : g_bad_params
            $error("nibble_splitter: WORD_W must be a multiple of PART_W and >= 2*PART_W");
        end
    endgenerate

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx;
    logic              idx_last;
    logic              slice_done;
    logic              accept;

    // Output beat handshake; only meaningful while a word is being sent.
    assign slice_done = (state_q == ST_SEND) && bus.out_ready;

    // The buffer frees up either when idle or on the final slice's handshake,
    // which is what lets a new word land in the same cycle with no bubble.
    assign bus.in_ready = !rst && ((state_q == ST_IDLE) || (slice_done && idx_last));
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (slice_done && idx_last && !bus.in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (accept) begin
            word_q <= bus.in_data;
        end
    end

    part_counter #(
        .NUM_PARTS (NUM_PARTS),
        .IDX_W     (IDX_W)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (slice_done && !idx_last),
        .count (idx),
        .last  (idx_last)
    );

    // Outputs are forced to zero outside SEND so the idle bus is quiet.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        if (state_q == ST_SEND) begin
            bus.out_valid = 1'b1;
            bus.out_idx   = idx;
            bus.out_last  = idx_last;
            for (int unsigned k = 0; k < NUM_PARTS; k++) begin
                if (idx == IDX_W'(k)) begin
`ifdef SPLIT_LSB_FIRST_EN
                    bus.out_data = word_q[k*PART_W +: PART_W];
`else
                    bus.out_data = word_q[WORD_W-1-k*PART_W -: PART_W];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_splitter.sv
// -----------------------------------------------------------------------------
// tb_nibble_splitter
// Directed cycle table plus randomized traffic for an 8-bit/4-bit splitter,
// and a 16-bit/4-bit instance for the wide-word ordering case.
// Honours SPLIT_LSB_FIRST_EN for expected slice order.
// -----------------------------------------------------------------------------
module tb_nibble_splitter;
    import splitter_pkg::*;

`ifdef SPLIT_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_splitter_if #(.WORD_W(8),  .PART_W(4)) b8 ();
    nibble_splitter_if #(.WORD_W(16), .PART_W(4)) b16 ();

    nibble_splitter #(.WORD_W(8),  .PART_W(4)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
    nibble_splitter #(.WORD_W(16), .PART_W(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed row = one cycle: inputs applied, outputs expected in that cycle.
    typedef struct {
        bit         r;
        bit         iv;
        logic [7:0] id;
        bit         ordy;
        bit         ov;
        logic [3:0] dm;    // expected slice, MSB-first build
        logic [3:0] dl;    // expected slice, LSB-first build
        logic       idx;
        bit         last;
        bit         ir;
        bit         full;  // also check data/idx while idle (reset state)
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, bit iv, logic [7:0] id, bit ordy, bit ov,
                                logic [3:0] dm, logic [3:0] dl, logic idx,
                                bit last, bit ir, bit full);
        vec_t v;
        v.r = r; v.iv = iv; v.id = id; v.ordy = ordy; v.ov = ov;
        v.dm = dm; v.dl = dl; v.idx = idx; v.last = last; v.ir = ir; v.full = full;
        return v;
    endfunction

    // Reference model for random traffic: a queue of the slices still owed.
    typedef struct {
        logic [3:0]  d;
        int unsigned k;
        bit          last;
    } sl_t;

    sl_t        mq[$];
    logic [7:0] mword;
    logic [7:0] acc;

    initial begin
        logic [3:0]  exp16[4];
        logic [15:0] w16;
        bit          hold;
        bit          busy;
        bit          exp_ir;
        logic [7:0]  cur_data;
        bit          cur_iv;
        bit          cur_or;
        bit          cur_rst;
        logic [7:0]  tmp;
        sl_t         s;

        rst = 1'b1;
        b8.in_valid  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b1;
        tick();
        tick();

        //         r iv id    or ov dm    dl    idx last ir full
        vt.push_back(mk(1,0,8'h00,1, 0,4'h0,4'h0,0,0,0,1)); // reset state
        vt.push_back(mk(0,1,8'hA6,1, 0,4'h0,4'h0,0,0,1,0)); // single word
        vt.push_back(mk(0,0,8'h00,1, 1,4'hA,4'h6,0,0,0,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'h6,4'hA,1,1,1,0));
        vt.push_back(mk(0,0,8'h00,1, 0,4'h0,4'h0,0,0,1,0));
        vt.push_back(mk(0,1,8'hA6,0, 0,4'h0,4'h0,0,0,1,0)); // backpressure
        vt.push_back(mk(0,0,8'h00,0, 1,4'hA,4'h6,0,0,0,0));
        vt.push_back(mk(0,1,8'h55,0, 1,4'hA,4'h6,0,0,0,0)); // ignored while busy
        vt.push_back(mk(0,1,8'h55,0, 1,4'hA,4'h6,0,0,0,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'hA,4'h6,0,0,0,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'h6,4'hA,1,1,1,0));
        vt.push_back(mk(0,0,8'h00,1, 0,4'h0,4'h0,0,0,1,0));
        vt.push_back(mk(0,1,8'hA6,1, 0,4'h0,4'h0,0,0,1,0)); // back-to-back
        vt.push_back(mk(0,1,8'h3C,1, 1,4'hA,4'h6,0,0,0,0));
        vt.push_back(mk(0,1,8'h3C,1, 1,4'h6,4'hA,1,1,1,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'h3,4'hC,0,0,0,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'hC,4'h3,1,1,1,0));
        vt.push_back(mk(0,0,8'h00,1, 0,4'h0,4'h0,0,0,1,0));
        vt.push_back(mk(0,1,8'hF0,1, 0,4'h0,4'h0,0,0,1,0)); // reset mid-word
        vt.push_back(mk(1,0,8'h00,1, 1,4'hF,4'h0,0,0,0,0));
        vt.push_back(mk(0,1,8'h12,1, 0,4'h0,4'h0,0,0,1,1));
        vt.push_back(mk(0,0,8'h00,1, 1,4'h1,4'h2,0,0,0,0));
        vt.push_back(mk(0,0,8'h00,1, 1,4'h2,4'h1,1,1,1,0));
        vt.push_back(mk(0,0,8'h00,1, 0,4'h0,4'h0,0,0,1,0));

        for (int i = 0; i < vt.size(); i++) begin
            rst          = vt[i].r;
            b8.in_valid  = vt[i].iv;
            b8.in_data   = vt[i].id;
            b8.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d.out_valid", i), 32'(b8.out_valid), 32'(vt[i].ov));
            chk($sformatf("vec%0d.out_last", i),  32'(b8.out_last),  32'(vt[i].last));
            chk($sformatf("vec%0d.in_ready", i),  32'(b8.in_ready),  32'(vt[i].ir));
            if (vt[i].ov || vt[i].full) begin
                chk($sformatf("vec%0d.out_data", i), 32'(b8.out_data),
                    32'(LSB_FIRST ? vt[i].dl : vt[i].dm));
                chk($sformatf("vec%0d.out_idx", i), 32'(b8.out_idx), 32'(vt[i].idx));
            end
            tick();
        end
        b8.in_valid = 1'b0;

        // Wide word: four slices, last only on the fourth.
        if (LSB_FIRST) begin
            exp16[0] = 4'hF; exp16[1] = 4'hE; exp16[2] = 4'hE; exp16[3] = 4'hB;
        end else begin
            exp16[0] = 4'hB; exp16[1] = 4'hE; exp16[2] = 4'hE; exp16[3] = 4'hF;
        end
        w16 = 16'hBEEF;
        b16.in_valid = 1'b1;
        b16.in_data  = w16;
        #1;
        chk("w16.in_ready_idle", 32'(b16.in_ready), 32'd1);
        tick();
        b16.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("w16.s%0d.out_valid", k), 32'(b16.out_valid), 32'd1);
            chk($sformatf("w16.s%0d.out_data", k),  32'(b16.out_data),  32'(exp16[k]));
            chk($sformatf("w16.s%0d.out_idx", k),   32'(b16.out_idx),   32'(k));
            chk($sformatf("w16.s%0d.out_last", k),  32'(b16.out_last),  32'(k == 3));
            tick();
        end
        #1;
        chk("w16.done.out_valid", 32'(b16.out_valid), 32'd0);
        tick();

        // Randomized traffic on the 8-bit instance.
        mq.delete();
        acc      = '0;
        mword    = '0;
        hold     = 1'b0;
        cur_data = '0;
        for (int c = 0; c < 3000; c++) begin
            cur_rst = ($urandom_range(0, 99) == 0);
            cur_or  = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                cur_iv   = ($urandom_range(0, 2) != 0);
                cur_data = 8'($urandom);
            end else begin
                cur_iv = 1'b1;
            end
            rst          = cur_rst;
            b8.in_valid  = cur_iv;
            b8.in_data   = cur_data;
            b8.out_ready = cur_or;
            #1;
            busy   = (mq.size() != 0);
            exp_ir = !cur_rst && (!busy || (mq.size() == 1 && cur_or));
            chk("rnd.out_valid", 32'(b8.out_valid), 32'(busy));
            chk("rnd.in_ready",  32'(b8.in_ready),  32'(exp_ir));
            if (busy) begin
                chk("rnd.out_data", 32'(b8.out_data), 32'(mq[0].d));
                chk("rnd.out_idx",  32'(b8.out_idx),  32'(mq[0].k));
                chk("rnd.out_last", 32'(b8.out_last), 32'(mq[0].last));
            end
            tick();
            if (cur_rst) begin
                mq.delete();
                acc  = '0;
                hold = 1'b0;
            end else begin
                if (busy && cur_or) begin
                    s = mq.pop_front();
                    if (LSB_FIRST) begin
                        acc = acc | (8'(s.d) << (4 * s.k));
                    end else begin
                        acc = (acc << 4) | 8'(s.d);
                    end
                    if (s.last) begin
                        chk("rnd.reassemble", 32'(acc), 32'(mword));
                        acc = '0;
                    end
                end
                if (cur_iv && exp_ir) begin
                    for (int k = 0; k < 2; k++) begin
                        tmp    = cur_data >> (LSB_FIRST ? 4 * k : 4 - 4 * k);
                        s.d    = tmp[3:0];
                        s.k    = k;
                        s.last = (k == 1);
                        mq.push_back(s);
                    end
                    mword = cur_data;
                    acc   = '0;
                    hold  = 1'b0;
                end else begin
                    hold = cur_iv;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
